// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the multicycle control sequencer: state codes,
// default widths and instruction field positions.
package riscv_ctrl_pkg;

    localparam int          DFLT_PC_W     = 16;
    localparam logic [15:0] DFLT_RESET_PC = 16'h0000;

    // Instruction field positions
    localparam int OPC_MSB    = 15;
    localparam int OPC_LSB    = 12;
    localparam int JMP_MSB    = 11;
    localparam int BR_OFF_MSB = 5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_e;

    localparam logic [2:0] ST_IDLE   = S_IDLE;
    localparam logic [2:0] ST_FETCH  = S_FETCH;
    localparam logic [2:0] ST_DECODE = S_DECODE;
    localparam logic [2:0] ST_EXEC   = S_EXEC;
    localparam logic [2:0] ST_MEM    = S_MEM;
    localparam logic [2:0] ST_WB     = S_WB;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: sequential, PC-relative branch, or
// region-local jump. All arithmetic wraps modulo 2^PC_W.
module pc_next_calc
    import riscv_ctrl_pkg::*;
#(
    parameter int PC_W = DFLT_PC_W
) (
    input  logic [PC_W-1:0]    pc,
    input  logic [JMP_MSB:0]   ir_imm,
    input  logic               jump,
    input  logic               beq,
    input  logic               bne,
    input  logic               zero,
    output logic [PC_W-1:0]    next_pc
);

    logic [PC_W-1:0] pc_plus2;
    logic [PC_W-1:0] br_off;
    logic            taken;

    assign pc_plus2 = pc + PC_W'(2);
    // sext(ir[5:0]) << 1; the dropped top bit is only a sign copy
    assign br_off   = {{(PC_W-BR_OFF_MSB-1){ir_imm[BR_OFF_MSB]}}, ir_imm[BR_OFF_MSB-1:0], 1'b0};
    assign taken    = (beq & zero) | (bne & ~zero);

    always_comb begin
        next_pc = pc_plus2;
        if (jump)
            next_pc = {pc_plus2[PC_W-1:JMP_MSB+2], ir_imm, 1'b0};
        else if (taken)
            next_pc = pc_plus2 + br_off;
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control FSM with PC, instruction
// register and retired-instruction counter.
module multicycle_sequencer
    import riscv_ctrl_pkg::*;
#(
    parameter int              PC_W     = DFLT_PC_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DFLT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            halt_req,
    input  logic [PC_W-1:0] instruction,
    input  logic            jump,
    input  logic            beq,
    input  logic            bne,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            reg_write,
    input  logic            zero,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] ir,
    output logic [3:0]      opcode,
    output logic            reg_write_en,
    output logic            mem_read_en,
    output logic            mem_write_en,
    output logic [2:0]      state,
    output logic            busy,
    output logic [PC_W-1:0] instr_count
);

    logic [2:0]      state_nx;
    logic            retire;
    logic [PC_W-1:0] next_pc;
    // Memory direction captured in EXEC so MEM strobes depend on state alone
    logic            mem_rd_q;
    logic            mem_wr_q;

    pc_next_calc #(.PC_W(PC_W)) u_pc_next (
        .pc      (pc),
        .ir_imm  (ir[JMP_MSB:0]),
        .jump    (jump),
        .beq     (beq),
        .bne     (bne),
        .zero    (zero),
        .next_pc (next_pc)
    );

    always_comb begin
        state_nx = ST_IDLE;
        retire   = 1'b0;
        case (state)
            ST_IDLE:   state_nx = start ? ST_FETCH : ST_IDLE;
            ST_FETCH:  state_nx = ST_DECODE;
            ST_DECODE: state_nx = ST_EXEC;
            ST_EXEC: begin
                if (mem_read | mem_write) state_nx = ST_MEM;
                else if (reg_write)       state_nx = ST_WB;
                else                      retire   = 1'b1;
            end
            ST_MEM: begin
                if (mem_rd_q) state_nx = ST_WB;
                else          retire   = 1'b1;
            end
            ST_WB:     retire   = 1'b1;
            default:   state_nx = ST_IDLE;
        endcase
        if (retire)
            state_nx = halt_req ? ST_IDLE : ST_FETCH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            ir          <= '0;
            instr_count <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_FETCH)
                ir <= instruction;
            if (state == ST_EXEC) begin
                pc       <= next_pc;
                mem_rd_q <= mem_read;
                mem_wr_q <= mem_write & ~mem_read;
            end
            if (retire)
                instr_count <= instr_count + PC_W'(1);
        end
    end

    assign opcode       = ir[OPC_MSB:OPC_LSB];
    assign busy         = (state != ST_IDLE);
    assign mem_read_en  = (state == ST_MEM) & mem_rd_q;
    assign mem_write_en = (state == ST_MEM) & mem_wr_q;
    assign reg_write_en = (state == ST_WB);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: directed program plus random instruction
// stream checked against a per-instruction latency/PC model.
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        halt_req;
    logic [15:0] instruction;
    logic        jump, beq, bne, mem_read, mem_write, reg_write;
    logic        zero;
    logic [15:0] pc, ir, instr_count;
    logic [3:0]  opcode;
    logic        reg_write_en, mem_read_en, mem_write_en;
    logic [2:0]  state;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference state
    int m_pc  = 0;
    int m_cnt = 0;
    bit m_idle = 1;

    localparam int C_ALU = 0, C_LD = 1, C_ST = 2, C_BEQ = 3, C_BNE = 4, C_JMP = 5, C_NOP = 6;

    multicycle_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .halt_req     (halt_req),
        .instruction  (instruction),
        .jump         (jump),
        .beq          (beq),
        .bne          (bne),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .reg_write    (reg_write),
        .zero         (zero),
        .pc           (pc),
        .ir           (ir),
        .opcode       (opcode),
        .reg_write_en (reg_write_en),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .state        (state),
        .busy         (busy),
        .instr_count  (instr_count)
    );

    always #5 clk = ~clk;

    function automatic int cls_of(input logic [3:0] op);
        case (op)
            4'h1:    return C_LD;
            4'h2:    return C_ST;
            4'h3:    return C_BEQ;
            4'h4:    return C_BNE;
            4'h5:    return C_JMP;
            4'h6:    return C_NOP;
            default: return C_ALU;
        endcase
    endfunction

    // Environment control unit: decodes the DUT's opcode output
    always_comb begin
        {jump, beq, bne, mem_read, mem_write, reg_write} = 6'b0;
        case (cls_of(opcode))
            C_LD:    begin mem_read = 1'b1; reg_write = 1'b1; end
            C_ST:    mem_write = 1'b1;
            C_BEQ:   beq  = 1'b1;
            C_BNE:   bne  = 1'b1;
            C_JMP:   jump = 1'b1;
            C_NOP:   ;
            default: reg_write = 1'b1;
        endcase
    end

    function automatic int model_pc(input int p, input logic [15:0] ins, input logic z);
        int c, nxt, off;
        c   = cls_of(ins[15:12]);
        nxt = (p + 2) % 65536;
        off = int'(ins[5:0]);
        if (off >= 32) off -= 64;
        if (c == C_JMP)
            return (nxt / 8192) * 8192 + int'(ins[11:0]) * 2;
        if ((c == C_BEQ && z) || (c == C_BNE && !z))
            return (p + 2 + 2 * off + 65536) % 65536;
        return nxt;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_instr(input logic [15:0] ins, input logic z, input logic hlt);
        int seq[$];
        int c, new_pc;
        c = cls_of(ins[15:12]);
        seq = '{1, 2, 3};
        if (c == C_LD) begin seq.push_back(4); seq.push_back(5); end
        else if (c == C_ST) seq.push_back(4);
        else if (c == C_ALU) seq.push_back(5);
        new_pc = model_pc(m_pc, ins, z);
        instruction = ins;
        zero = z;
        if (m_idle) begin
            start = 1'b1;
            @(negedge clk);
        end
        for (int i = 0; i < seq.size(); i++) begin
            chk("state", state, seq[i]);
            chk("busy", busy, 1);
            chk("pc", pc, (i < 3) ? m_pc : new_pc);
            chk("mem_read_en", mem_read_en, (seq[i] == 4) && (c == C_LD));
            chk("mem_write_en", mem_write_en, (seq[i] == 4) && (c == C_ST));
            chk("reg_write_en", reg_write_en, seq[i] == 5);
            if (i == 1) begin
                chk("ir", ir, ins);
                chk("opcode", opcode, ins[15:12]);
                halt_req = hlt;
            end
            start = 1'($urandom_range(1));
            @(negedge clk);
        end
        start = 1'b0;
        m_pc = new_pc;
        m_cnt = (m_cnt + 1) % 65536;
        m_idle = hlt;
        halt_req = 1'b0;
        chk("next_state", state, hlt ? 0 : 1);
        chk("pc_after", pc, m_pc);
        chk("instr_count", instr_count, m_cnt);
        if (hlt) begin
            chk("busy_idle", busy, 0);
            @(negedge clk);
            chk("idle_hold", state, 0);
            chk("pc_hold", pc, m_pc);
        end
    endtask

    task automatic reset_in(input logic [15:0] ins, input logic [2:0] target);
        int n;
        n = 0;
        instruction = ins;
        zero = 1'b0;
        if (m_idle) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        while (state !== target && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("reach_target", state, target);
        chk("strobe_pre", reg_write_en | mem_read_en | mem_write_en, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_state", state, 0);
        chk("rst_pc", pc, 0);
        chk("rst_ir", ir, 0);
        chk("rst_cnt", instr_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {reg_write_en, mem_read_en, mem_write_en}, 0);
        m_pc = 0;
        m_cnt = 0;
        m_idle = 1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_idle", state, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        halt_req = 1'b0;
        instruction = '0;
        zero = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", state, 0);
        chk("reset_pc", pc, 0);
        chk("reset_ir", ir, 0);
        chk("reset_cnt", instr_count, 0);
        chk("reset_busy", busy, 0);
        chk("reset_strobes", {reg_write_en, mem_read_en, mem_write_en}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_wait_start", state, 0);

        // Directed program walk
        run_instr(16'h0123, 1'b0, 1'b0);   // ALU at 0 -> pc 2
        run_instr(16'h303E, 1'b1, 1'b0);   // beq -2 at 2 -> 0
        run_instr(16'h303E, 1'b1, 1'b0);   // beq -2 at 0 -> FFFE
        run_instr(16'h5004, 1'b0, 1'b0);   // jump at FFFE -> 0008
        run_instr(16'h5008, 1'b0, 1'b0);   // jump -> 0010
        run_instr(16'h1000, 1'b0, 1'b0);   // load at 0010 -> 0012
        run_instr(16'h4005, 1'b1, 1'b0);   // bne not taken -> 0014
        run_instr(16'h4002, 1'b0, 1'b0);   // bne taken -> 001A
        run_instr(16'h5010, 1'b0, 1'b0);   // jump -> 0020
        run_instr(16'h303E, 1'b1, 1'b0);   // beq -2 at 0020 -> 001E
        run_instr(16'h303E, 1'b0, 1'b0);   // beq not taken -> 0020
        run_instr(16'h2000, 1'b0, 1'b1);   // store with halt -> IDLE at 0022
        run_instr(16'h6000, 1'b0, 1'b0);   // restart, control-free op

        for (int k = 0; k < 200; k++)
            run_instr(16'($urandom), 1'($urandom_range(1)), ($urandom_range(7) == 0));

        reset_in(16'h2000, 3'd4);          // reset during MEM of a store
        reset_in(16'h0000, 3'd5);          // reset during WB of an ALU op
        run_instr(16'h0AAA, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 16, the PC, instruction and retired-count width.
REQ-002 SHALL have parameter RESET_PC, default 16'h0000, the PC value loaded on reset.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  level; begins execution from IDLE.
REQ-006 SHALL have port halt_req  input  1  level; stop at the next instruction boundary.
REQ-007 SHALL have port instruction  input  PC_W  word returned by Instruction_Memory for pc.
REQ-008 SHALL have ports jump, beq, bne, mem_read, mem_write, reg_write  input  1 each  Control_Unit decode of opcode.
REQ-009 SHALL have port zero  input  1  ALU zero flag.
REQ-010 SHALL have port pc  output  PC_W  program counter driven to Instruction_Memory.
REQ-011 SHALL have port ir  output  PC_W  latched instruction register.
REQ-012 SHALL have port opcode  output  4  ir[15:12], driven to Control_Unit.
REQ-013 SHALL have ports reg_write_en, mem_read_en, mem_write_en  output  1 each  one-cycle strobes to GPRs and Data_Memory.
REQ-014 SHALL have port state  output  3  current FSM state encoding.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port instr_count  output  PC_W  count of retired instructions.

Function
REQ-017 SHALL implement the states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, with codes 6-7 returning to IDLE on the next edge.
REQ-018 From IDLE, start=1 SHALL transition to FETCH, and start SHALL be ignored when busy=1.
REQ-019 In FETCH, the FSM SHALL latch ir<=instruction and SHALL go to DECODE.
REQ-020 DECODE SHALL go to EXEC, and decode inputs SHALL be sampled only in EXEC, MEM and WB.
REQ-021 At the end of EXEC, pc SHALL be updated with pc+2 by default; beq&zero or bne&!zero SHALL give pc+2+(sext(ir[5:0])<<1); jump SHALL give {pc_plus2[15:13], ir[11:0], 1'b0}; jump takes priority.
REQ-022 All PC arithmetic SHALL be modulo 2^PC_W, with 16'hFFFE+2 wrapping to 16'h0000.
REQ-023 EXEC SHALL exit as follows: to MEM if mem_read|mem_write, else to WB if reg_write, else the instruction retires.
REQ-024 MEM SHALL assert mem_read_en=mem_read and mem_write_en=mem_write for exactly one cycle, then go to WB if mem_read, else the instruction retires.
REQ-025 WB SHALL assert reg_write_en for exactly one cycle, then the instruction retires.
REQ-026 On retirement, instr_count SHALL increment (wrapping at 16'hFFFF to 0), and the next state SHALL be IDLE if halt_req=1, else FETCH.
REQ-027 Latencies SHALL be: ALU instruction 4 cycles, load 5, store 4, branch or jump 3.
REQ-028 Strobes SHALL be Moore outputs of state, mutually exclusive, and never asserted in IDLE, FETCH, DECODE or EXEC.
REQ-029 halt_req asserted mid-instruction SHALL NOT abort the instruction, and SHALL take effect only at retirement.
REQ-030 pc, ir and instr_count SHALL hold their values in IDLE, so that restarting resumes at the held pc.

Reset
REQ-031 rst_n=0 SHALL, asynchronously and in any state, force state=IDLE, pc=RESET_PC, ir=0, instr_count=0, busy=0 and all strobes=0.
REQ-032 Reset asserted during MEM or WB SHALL deassert the active strobe immediately, with no partial write.
REQ-033 After rst_n rises, the FSM SHALL remain in IDLE until start is sampled at 1 on a rising clk edge.

Structure
REQ-034 Package riscv_ctrl_pkg SHALL hold the state enum, PC_W, RESET_PC and the opcode field bit positions.
REQ-035 One sub-module, pc_next_calc, SHALL be combinational and compute the REQ-021 next PC from pc, ir, jump, beq, bne and zero.
REQ-036 The FSM, registers and counter SHALL reside in multicycle_sequencer.

Verification
REQ-037 Reset, then start=1 with an ALU instruction (reg_write=1) -> state sequence 1,2,3,5,1, reg_write_en high only in cycle 4, pc=2, instr_count=1.
REQ-038 Load at pc=16'h0010 (mem_read=1, reg_write=1) -> mem_read_en in cycle 4, reg_write_en in cycle 5, pc=16'h0012.
REQ-039 beq with ir[5:0]=6'h3E (-2), zero=1, pc=16'h0020 -> pc=16'h001E after EXEC, no strobes, 3 cycles.
REQ-040 jump at pc=16'hFFFE with ir[11:0]=12'h004 -> pc_plus2 wraps to 16'h0000, new pc=16'h0008.
REQ-041 Store with halt_req raised during DECODE -> mem_write_en pulses once, then IDLE, busy=0, pc held.
REQ-042 rst_n dropped mid-WB -> reg_write_en=0 within the same cycle, state=0, pc=RESET_PC.
